// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-latched, maskable interrupt controller with ack timeout and EOI handshake
module irq_ctrl #(
   parameter int NSRC        = 4,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NSRC-1:0] src_req,
   input  logic            cpu_kernel,
   input  logic            bus_rd,
   input  logic            bus_wr,
   input  logic [1:0]      bus_addr,
   input  logic [31:0]     bus_wdata,
   output logic [31:0]     bus_rdata,
   output logic            irq,
   output logic [1:0]      irq_id
);
   typedef enum logic [1:0] {IDLE = 2'd0, ASSERT = 2'd1, SERVICE = 2'd2} state_t;
   state_t state, state_n;
   logic [NSRC-1:0] src_q, pend, mask, elig, rise, clr;
   logic [1:0] pick;
   logic [7:0] cnt;
   logic wr_pend, wr_mask, wr_eoi, start, ack;
   logic unused_wdata;
   assign unused_wdata = &{1'b0, bus_wdata[31:NSRC]};
   assign rise    = src_req & ~src_q;
   assign elig    = pend & mask;
   assign wr_pend = bus_wr && bus_addr == 2'd0;
   assign wr_mask = bus_wr && bus_addr == 2'd1;
   assign wr_eoi  = bus_wr && bus_addr == 2'd3;
   assign irq     = state == ASSERT;
   assign clr     = (wr_pend ? bus_wdata[NSRC-1:0] : '0) | (ack ? NSRC'(1) << irq_id : '0);
   // lowest eligible index wins arbitration
   always_comb begin
      pick = '0;
      for (int i = NSRC - 1; i >= 0; i--) if (elig[i]) pick = 2'(i);
   end
   // next-state logic; start marks a new assertion, ack marks CPU entry
   always_comb begin
      state_n = state;
      start   = 1'b0;
      ack     = 1'b0;
      case (state)
         IDLE: if (|elig && !cpu_kernel) begin
            state_n = ASSERT;
            start   = 1'b1;
         end
         ASSERT: if (cpu_kernel) begin
            state_n = SERVICE;
            ack     = 1'b1;
         end else if (!mask[irq_id] || cnt == 8'(ACK_TIMEOUT - 1)) state_n = IDLE;
         SERVICE: if (wr_eoi) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   // FSM state register
   always_ff @(posedge clk) state <= reset ? IDLE : state_n;
   // pending/mask/id/timeout state; a same-cycle rising edge beats any clear
   always_ff @(posedge clk) begin
      if (reset) begin
         src_q  <= '0;
         pend   <= '0;
         mask   <= '0;
         irq_id <= '0;
         cnt    <= '0;
      end else begin
         src_q  <= src_req;
         pend   <= (pend & ~clr) | rise;
         mask   <= wr_mask ? bus_wdata[NSRC-1:0] : mask;
         irq_id <= start ? pick : irq_id;
         cnt    <= start ? 8'd0 : (state == ASSERT && cnt != 8'(ACK_TIMEOUT)) ? cnt + 8'd1 : cnt;
      end
   end
   // register read mux, zero when not reading
   always_comb begin
      bus_rdata = !bus_rd            ? 32'd0 :
                  bus_addr == 2'd0   ? {{(32-NSRC){1'b0}}, pend} :
                  bus_addr == 2'd1   ? {{(32-NSRC){1'b0}}, mask} :
                  bus_addr == 2'd2   ? {state, 28'd0, irq_id} : 32'd0;
   end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed self-checking bench for irq_ctrl
module tb_irq_ctrl;
   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  src_req;
   logic        cpu_kernel, bus_rd, bus_wr;
   logic [1:0]  bus_addr;
   logic [31:0] bus_wdata, bus_rdata, rd_val;
   logic        irq;
   logic [1:0]  irq_id;
   int checks = 0;
   int errors = 0;
   int n;

   localparam logic [1:0] A_PEND = 2'd0, A_MASK = 2'd1, A_CAUSE = 2'd2, A_EOI = 2'd3;

   irq_ctrl #(.NSRC(4), .ACK_TIMEOUT(255)) dut (
      .clk(clk), .reset(reset), .src_req(src_req), .cpu_kernel(cpu_kernel),
      .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .irq(irq), .irq_id(irq_id)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      bus_rd = 1'b1;
      bus_addr = a;
      #1;
      d = bus_rdata;
      bus_rd = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus_wr = 1'b1;
      bus_addr = a;
      bus_wdata = d;
      step();
      bus_wr = 1'b0;
   endtask

   initial begin
      reset = 1'b1; src_req = '0; cpu_kernel = 1'b0;
      bus_rd = 1'b0; bus_wr = 1'b0; bus_addr = '0; bus_wdata = '0;
      step(); step();
      reset = 1'b0;
      step();
      chk("rst_irq", {31'd0, irq}, 32'd0);
      chk("rst_id", {30'd0, irq_id}, 32'd0);
      rd(A_PEND, rd_val);  chk("rst_pend", rd_val, 32'd0);
      rd(A_MASK, rd_val);  chk("rst_mask", rd_val, 32'd0);
      rd(A_CAUSE, rd_val); chk("rst_cause", rd_val, 32'd0);

      // single source basic flow
      wr(A_MASK, 32'h1);
      rd(A_MASK, rd_val); chk("mask_rw", rd_val, 32'h1);
      src_req = 4'b0001;
      step();
      src_req = 4'b0000;
      rd(A_PEND, rd_val); chk("s0_pend", rd_val, 32'h1);
      chk("s0_no_irq_yet", {31'd0, irq}, 32'd0);
      step();
      chk("s0_irq", {31'd0, irq}, 32'd1);
      chk("s0_id", {30'd0, irq_id}, 32'd0);
      cpu_kernel = 1'b1;
      step();
      chk("s0_svc_irq", {31'd0, irq}, 32'd0);
      rd(A_CAUSE, rd_val); chk("s0_cause_svc", rd_val, 32'h8000_0000);
      rd(A_PEND, rd_val);  chk("s0_pend_clr", rd_val, 32'd0);
      rd(A_EOI, rd_val);   chk("eoi_read", rd_val, 32'd0);
      wr(A_EOI, 32'd0);
      cpu_kernel = 1'b0;
      step();
      rd(A_CAUSE, rd_val); chk("s0_cause_idle", rd_val, 32'd0);
      chk("s0_idle_irq", {31'd0, irq}, 32'd0);

      // priority and re-arbitration after EOI
      wr(A_MASK, 32'hF);
      src_req = 4'b0110;
      step();
      step();
      chk("pri_irq", {31'd0, irq}, 32'd1);
      chk("pri_id1", {30'd0, irq_id}, 32'd1);
      cpu_kernel = 1'b1;
      step();
      src_req = 4'b0000;
      rd(A_PEND, rd_val); chk("pri_pend", rd_val, 32'h4);
      chk("pri_svc_irq", {31'd0, irq}, 32'd0);
      wr(A_EOI, 32'd0);
      cpu_kernel = 1'b0;
      step();
      chk("rearb_irq", {31'd0, irq}, 32'd1);
      chk("rearb_id2", {30'd0, irq_id}, 32'd2);
      cpu_kernel = 1'b1;
      step();
      wr(A_EOI, 32'd0);
      cpu_kernel = 1'b0;
      step();
      chk("drain_irq", {31'd0, irq}, 32'd0);

      // W1C racing a new edge, EOI in ASSERT ignored, mask-clear withdrawal
      src_req = 4'b0001;
      wr(A_PEND, 32'h1);
      rd(A_PEND, rd_val); chk("w1c_race", rd_val, 32'h1);
      step();
      chk("race_irq", {31'd0, irq}, 32'd1);
      wr(A_EOI, 32'd0);
      chk("eoi_in_assert", {31'd0, irq}, 32'd1);
      wr(A_MASK, 32'h0);
      step();
      chk("mask_withdraw", {31'd0, irq}, 32'd0);
      rd(A_PEND, rd_val); chk("withdraw_pend", rd_val, 32'h1);
      wr(A_PEND, 32'h1);
      rd(A_PEND, rd_val); chk("w1c_plain", rd_val, 32'h0);
      src_req = 4'b0000;

      // ack timeout
      wr(A_MASK, 32'h1);
      src_req = 4'b0001;
      step();
      src_req = 4'b0000;
      step();
      chk("to_irq", {31'd0, irq}, 32'd1);
      n = 0;
      for (int i = 0; i < 300 && irq; i++) begin
         step();
         n++;
      end
      chk("to_len", n, 32'd255);
      chk("to_irq_low", {31'd0, irq}, 32'd0);
      rd(A_CAUSE, rd_val); chk("to_cause", rd_val, 32'd0);
      rd(A_PEND, rd_val);  chk("to_pend", rd_val, 32'h1);
      step();
      chk("to_reassert", {31'd0, irq}, 32'd1);
      cpu_kernel = 1'b1;
      step();
      wr(A_EOI, 32'd0);
      cpu_kernel = 1'b0;
      step();
      chk("to_done", {31'd0, irq}, 32'd0);

      // masked source, then unmasked
      wr(A_MASK, 32'h0);
      src_req = 4'b1000;
      step(); step(); step();
      chk("masked_no_irq", {31'd0, irq}, 32'd0);
      rd(A_PEND, rd_val); chk("masked_pend", rd_val, 32'h8);
      wr(A_MASK, 32'h8);
      step();
      chk("unmask_irq", {31'd0, irq}, 32'd1);
      chk("unmask_id3", {30'd0, irq_id}, 32'd3);
      cpu_kernel = 1'b1;
      step();
      src_req = 4'b0000;

      // reset while in SERVICE
      wr(A_MASK, 32'hF);
      rd(A_CAUSE, rd_val); chk("svc_cause", rd_val, 32'h8000_0003);
      reset = 1'b1;
      step();
      reset = 1'b0;
      cpu_kernel = 1'b0;
      chk("rst_svc_irq", {31'd0, irq}, 32'd0);
      rd(A_CAUSE, rd_val); chk("rst_svc_cause", rd_val, 32'd0);
      rd(A_MASK, rd_val);  chk("rst_svc_mask", rd_val, 32'd0);

      // level held through reset counts as an edge
      src_req = 4'b0001;
      reset = 1'b1;
      step();
      reset = 1'b0;
      rd(A_PEND, rd_val); chk("held_in_rst", rd_val, 32'd0);
      step();
      rd(A_PEND, rd_val); chk("post_rst_edge", rd_val, 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
